// File: rtl/mmio_bridge_pkg.sv
// Shared constants and types for the MMIO bridge: IO address map, region decode,
// FSM state encoding and the read-data source selector.
package mmio_bridge_pkg;
   localparam logic [31:0] IO_RX_ADDR  = 32'h0003_0000;
   localparam logic [31:0] IO_CNT_ADDR = 32'h0003_0004;
   localparam logic [1:0]  IO_REGION   = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STOPPING = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_ZERO = 3'd0,
      SRC_RAM  = 3'd1,
      SRC_RX   = 3'd2,
      SRC_CNT0 = 3'd3,
      SRC_CNT1 = 3'd4,
      SRC_CNT2 = 3'd5,
      SRC_CNT3 = 3'd6
   } rd_src_t;

   function automatic logic is_io(input logic [31:0] a);
      return a[17:16] == IO_REGION;
   endfunction
endpackage

// File: rtl/mmio_bridge_if.sv
// CPU, RAM and UART signal bundle of the MMIO bridge; slave is the bridge side.
interface mmio_bridge_if #(
   parameter int RAM_ABITS = 17
);
   logic [31:0]          cpu_a;
   logic [7:0]           cpu_dout;
   logic                 cpu_wr;
   logic [7:0]           cpu_din;
   logic                 cpu_rdy;
   logic [RAM_ABITS-1:0] ram_a;
   logic [7:0]           ram_dout;
   logic                 ram_we;
   logic [7:0]           ram_din;
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 rx_pop;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 io_buffer_full;
   logic                 halt;

   modport slave (
      input  cpu_a, cpu_dout, cpu_wr, ram_din, rx_data, rx_valid, io_buffer_full,
      output cpu_din, cpu_rdy, ram_a, ram_dout, ram_we, rx_pop, tx_data, tx_valid, halt
   );

   modport master (
      output cpu_a, cpu_dout, cpu_wr, ram_din, rx_data, rx_valid, io_buffer_full,
      input  cpu_din, cpu_rdy, ram_a, ram_dout, ram_we, rx_pop, tx_data, tx_valid, halt
   );
endinterface

// File: rtl/mmio_txq.sv
// Byte FIFO for the UART transmit path; power-of-two depth, pointers wrap naturally.
module mmio_txq #(
   parameter int DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     en,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               push_data,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] hd, tl;

   assign head = mem[hd];

   always_ff @(posedge clk_in) begin
      if (en && push) mem[tl] <= push_data;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
      end else if (en) begin
         if (push) tl <= tl + 1'b1;
         if (pop)  hd <= hd + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/mmio_bridge.sv
// CPU-side MMIO bridge: RAM pass-through, UART RX read / TX queue, cycle counter
// snapshot and the RUN -> STOPPING -> HALTED shutdown sequence.
module mmio_bridge
   import mmio_bridge_pkg::*;
#(
   parameter int TXQ_DEPTH = 8,
   parameter int RAM_ABITS = 17
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   mmio_bridge_if.slave bus
);
   localparam int CW = $clog2(TXQ_DEPTH) + 1;

   state_t        state;
   rd_src_t       src;
   logic [7:0]    rx_q, head, push_data;
   logic [31:0]   cyc, snap;
   logic [CW-1:0] count;
   logic          run, io, rd, wr, push, pop, halt_q;

   // Reset gates the strobes so nothing leaks out during the reset cycle.
   assign run         = rdy_in & rst_in;
   assign io          = is_io(bus.cpu_a);
   assign bus.cpu_rdy = run & (count != CW'(TXQ_DEPTH)) & (state != ST_HALTED);
   assign wr          = bus.cpu_rdy & bus.cpu_wr;
   assign rd          = bus.cpu_rdy & ~bus.cpu_wr;

   assign bus.ram_a    = bus.cpu_a[RAM_ABITS-1:0];
   assign bus.ram_dout = bus.cpu_dout;
   assign bus.ram_we   = wr & ~io;
   assign bus.rx_pop   = rd & io & (bus.cpu_a == IO_RX_ADDR) & bus.rx_valid;

   assign pop          = run & (count != '0) & ~bus.io_buffer_full;
   assign bus.tx_valid = pop;
   assign bus.tx_data  = head;
   assign bus.halt     = halt_q;

   // Once stopping, IO writes are ignored; zero data bytes never enter the queue.
   always_comb begin
      push      = 1'b0;
      push_data = bus.cpu_dout;
      if (wr && io && state == ST_RUN) begin
         if (bus.cpu_a == IO_RX_ADDR && bus.cpu_dout != 8'h00) begin
            push = 1'b1;
         end else if (bus.cpu_a == IO_CNT_ADDR) begin
            push      = 1'b1;
            push_data = 8'h00;
         end
      end
   end

   mmio_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .head      (head),
      .count     (count)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cyc  <= '0;
         snap <= '0;
         src  <= SRC_ZERO;
         rx_q <= '0;
      end else if (rdy_in) begin
         cyc <= cyc + 32'd1;
         src <= SRC_ZERO;
         if (rd) begin
            if (!io) begin
               src <= SRC_RAM;
            end else begin
               case (bus.cpu_a)
                  IO_RX_ADDR: if (bus.rx_valid) begin
                     src  <= SRC_RX;
                     rx_q <= bus.rx_data;
                  end
                  IO_CNT_ADDR: begin
                     src  <= SRC_CNT0;
                     snap <= cyc;
                  end
                  IO_CNT_ADDR + 32'd1: src <= SRC_CNT1;
                  IO_CNT_ADDR + 32'd2: src <= SRC_CNT2;
                  IO_CNT_ADDR + 32'd3: src <= SRC_CNT3;
                  default: src <= SRC_ZERO;
               endcase
            end
         end
      end
   end

   always_comb begin
      bus.cpu_din = 8'h00;
      case (src)
         SRC_RAM:  bus.cpu_din = bus.ram_din;
         SRC_RX:   bus.cpu_din = rx_q;
         SRC_CNT0: bus.cpu_din = snap[7:0];
         SRC_CNT1: bus.cpu_din = snap[15:8];
         SRC_CNT2: bus.cpu_din = snap[23:16];
         SRC_CNT3: bus.cpu_din = snap[31:24];
         default:  bus.cpu_din = 8'h00;
      endcase
   end

   // The only zero byte ever queued is the terminator, so a zero at the head marks it.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state  <= ST_RUN;
         halt_q <= 1'b0;
      end else if (rdy_in) begin
         case (state)
            ST_RUN: if (push && bus.cpu_a == IO_CNT_ADDR) state <= ST_STOPPING;
            ST_STOPPING: if (pop && head == 8'h00) begin
               state  <= ST_HALTED;
               halt_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed scenarios plus randomized traffic checked against
// a transaction-level model (byte queue, counter, flags) every cycle.
module tb_mmio_bridge;
   import mmio_bridge_pkg::*;

   localparam int DEPTH = 8;
   localparam int RAB   = 17;
   localparam logic [31:0] RX   = 32'h0003_0000;
   localparam logic [31:0] CNT  = 32'h0003_0004;
   localparam logic [31:0] IDLE = 32'h0003_0010;

   logic clk_in = 1'b0;
   logic rst_in, rdy_in;

   mmio_bridge_if #(.RAM_ABITS(RAB)) bus();

   mmio_bridge #(.TXQ_DEPTH(DEPTH), .RAM_ABITS(RAB)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   // Environment RAM with one-cycle read latency.
   logic [7:0] ram [256] = '{default: 8'h00};
   always @(posedge clk_in) begin
      if (bus.ram_we) ram[bus.ram_a[7:0]] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_a[7:0]];
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   logic [7:0]  m_q [$];
   logic [7:0]  m_mem [256] = '{default: 8'h00};
   logic [31:0] m_cnt = 0, m_snap = 0;
   logic        m_halted = 0, m_stop = 0, m_chk_din = 0;
   logic [7:0]  m_din = 0;
   logic        acc;
   logic [7:0]  txlog [$];
   logic        o_rdy, o_txv, o_halt, o_we, o_pop;
   logic [7:0]  o_din;

   task automatic cycle();
      logic        io, e_rdy, e_txv, e_we, e_pop;
      logic [31:0] a;
      logic [7:0]  b;
      int          sh;
      @(negedge clk_in);
      a     = bus.cpu_a;
      io    = (a[17:16] == 2'b11);
      e_rdy = rst_in && rdy_in && (m_q.size() < DEPTH) && !m_halted;
      e_txv = rst_in && rdy_in && (m_q.size() > 0) && !bus.io_buffer_full;
      e_we  = e_rdy && bus.cpu_wr && !io;
      e_pop = e_rdy && !bus.cpu_wr && (a == RX) && bus.rx_valid;
      o_rdy = bus.cpu_rdy; o_txv = bus.tx_valid; o_halt = bus.halt;
      o_we  = bus.ram_we;  o_pop = bus.rx_pop;   o_din  = bus.cpu_din;
      chk("cpu_rdy", 32'(o_rdy), 32'(e_rdy));
      chk("tx_valid", 32'(o_txv), 32'(e_txv));
      chk("ram_we", 32'(o_we), 32'(e_we));
      chk("rx_pop", 32'(o_pop), 32'(e_pop));
      chk("halt", 32'(o_halt), 32'(m_halted));
      if (e_txv) chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
      if (e_we) begin
         chk("ram_a", 32'(bus.ram_a), 32'(a[16:0]));
         chk("ram_dout", 32'(bus.ram_dout), 32'(bus.cpu_dout));
      end
      if (m_chk_din) chk("cpu_din", 32'(o_din), 32'(m_din));
      if (o_txv) txlog.push_back(bus.tx_data);
      acc = e_rdy;
      if (!rst_in) begin
         m_q.delete();
         m_cnt = 0; m_snap = 0; m_halted = 0; m_stop = 0;
         m_din = 8'h00; m_chk_din = 1;
      end else if (rdy_in) begin
         m_chk_din = 0;
         if (e_txv) begin
            b = m_q.pop_front();
            if (m_stop && b == 8'h00) m_halted = 1;
         end
         if (e_rdy && bus.cpu_wr) begin
            if (!io) m_mem[a[7:0]] = bus.cpu_dout;
            else if (!m_stop) begin
               if (a == RX && bus.cpu_dout != 8'h00) m_q.push_back(bus.cpu_dout);
               else if (a == CNT) begin
                  m_q.push_back(8'h00);
                  m_stop = 1;
               end
            end
         end else if (e_rdy) begin
            m_chk_din = 1;
            if (!io) m_din = m_mem[a[7:0]];
            else if (a == RX) m_din = bus.rx_valid ? bus.rx_data : 8'h00;
            else if (a >= CNT && a <= CNT + 32'd3) begin
               if (a == CNT) m_snap = m_cnt;
               sh    = 8 * int'(a - CNT);
               m_din = 8'(m_snap >> sh);
            end else m_din = 8'h00;
         end
         m_cnt = m_cnt + 32'd1;
      end else begin
         m_chk_din = 0;
      end
      @(posedge clk_in); #1;
   endtask

   task automatic set_idle();
      bus.cpu_a = IDLE; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      set_idle();
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic access(input logic [31:0] a, input logic [7:0] d, input logic w);
      int k;
      bus.cpu_a = a; bus.cpu_dout = d; bus.cpu_wr = w;
      for (k = 0; k < 100; k++) begin
         cycle();
         if (acc) break;
      end
      if (k >= 100) chk("access_timeout", 32'(k), 32'd0);
      set_idle();
   endtask

   task automatic drain(input int n, input int bound);
      set_idle();
      for (int k = 0; k < bound && txlog.size() < n; k++) cycle();
      chk("drain_count", 32'(txlog.size()), 32'(n));
   endtask

   initial begin
      set_idle();
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.io_buffer_full = 1'b0;
      rst_in = 1'b0; rdy_in = 1'b1;
      @(posedge clk_in); #1;

      // Reset state
      cycle();
      chk("rst_rdy", 32'(o_rdy), 32'd0);
      chk("rst_txv", 32'(o_txv), 32'd0);
      chk("rst_halt", 32'(o_halt), 32'd0);
      chk("rst_pop", 32'(o_pop), 32'd0);
      chk("rst_we", 32'(o_we), 32'd0);
      chk("rst_din", 32'(o_din), 32'd0);
      rst_in = 1'b1;

      // Counter snapshot at 0x1F3
      for (int k = 0; k < 1000 && m_cnt != 32'h1F3; k++) cycle();
      chk("cnt_align", m_cnt, 32'h1F3);
      access(CNT, 8'h00, 1'b0);
      access(CNT + 32'd1, 8'h00, 1'b0);
      chk("cnt_b0", 32'(o_din), 32'hF3);
      access(CNT + 32'd2, 8'h00, 1'b0);
      chk("cnt_b1", 32'(o_din), 32'h01);
      access(CNT + 32'd3, 8'h00, 1'b0);
      chk("cnt_b2", 32'(o_din), 32'h00);
      idle(1);
      chk("cnt_b3", 32'(o_din), 32'h00);

      // RAM write then read
      access(32'h0000_0010, 8'hA5, 1'b1);
      chk("ram_we_pulse", 32'(o_we), 32'd1);
      access(32'h0000_0010, 8'h00, 1'b0);
      chk("ram_we_rd", 32'(o_we), 32'd0);
      idle(1);
      chk("ram_rd", 32'(o_din), 32'hA5);

      // RX read with and without data
      bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
      access(RX, 8'h00, 1'b0);
      chk("rx_pop_pulse", 32'(o_pop), 32'd1);
      bus.rx_valid = 1'b0;
      access(RX, 8'h00, 1'b0);
      chk("rx_data", 32'(o_din), 32'h5A);
      idle(1);
      chk("rx_empty", 32'(o_din), 32'h00);

      // TX zero filter
      txlog.delete();
      access(RX, 8'h41, 1'b1);
      access(RX, 8'h00, 1'b1);
      access(RX, 8'h42, 1'b1);
      drain(2, 20);
      idle(3);
      chk("filt_n", 32'(txlog.size()), 32'd2);
      chk("filt_0", 32'(txlog[0]), 32'h41);
      chk("filt_1", 32'(txlog[1]), 32'h42);

      // Backpressure: queue of 8 stalls the 9th write
      bus.io_buffer_full = 1'b1;
      for (int i = 1; i <= 8; i++) access(RX, 8'(i), 1'b1);
      bus.cpu_a = RX; bus.cpu_dout = 8'd9; bus.cpu_wr = 1'b1;
      cycle();
      chk("bp_stall", 32'(o_rdy), 32'd0);
      bus.io_buffer_full = 1'b0;
      txlog.delete();
      cycle();
      chk("bp_stall_rel", 32'(o_rdy), 32'd0);
      cycle();
      chk("bp_resume", 32'(o_rdy), 32'd1);
      drain(9, 40);
      for (int i = 0; i < 9 && i < txlog.size(); i++) chk("bp_order", 32'(txlog[i]), 32'(i + 1));

      // Halt sequence
      bus.io_buffer_full = 1'b1;
      access(RX, 8'h11, 1'b1);
      access(RX, 8'h22, 1'b1);
      access(CNT, 8'h77, 1'b1);
      bus.io_buffer_full = 1'b0;
      txlog.delete();
      drain(3, 20);
      chk("halt_b0", 32'(txlog[0]), 32'h11);
      chk("halt_b1", 32'(txlog[1]), 32'h22);
      chk("halt_term", 32'(txlog[2]), 32'h00);
      chk("halt_pre", 32'(o_halt), 32'd0);
      cycle();
      chk("halt_set", 32'(o_halt), 32'd1);
      chk("halt_rdy", 32'(o_rdy), 32'd0);
      idle(3);
      chk("halt_rdy_hold", 32'(o_rdy), 32'd0);

      // Reset mid-drain with 5 queued
      rst_in = 1'b0; cycle(); rst_in = 1'b1;
      bus.io_buffer_full = 1'b1;
      for (int i = 0; i < 6; i++) access(RX, 8'(8'h60 + i), 1'b1);
      bus.io_buffer_full = 1'b0;
      idle(1);
      rst_in = 1'b0;
      cycle();
      chk("mid_rst_txv", 32'(o_txv), 32'd0);
      rst_in = 1'b1;
      access(CNT, 8'h00, 1'b0);
      chk("post_rst_txv", 32'(o_txv), 32'd0);
      chk("post_rst_halt", 32'(o_halt), 32'd0);
      idle(1);
      chk("cnt_restart", 32'(o_din), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         rst_in = ($urandom_range(0, 299) != 0);
         rdy_in = ($urandom_range(0, 7) != 0);
         bus.io_buffer_full = ($urandom_range(0, 2) == 0);
         bus.rx_valid = 1'($urandom_range(0, 1));
         bus.rx_data  = 8'($urandom);
         bus.cpu_wr   = 1'($urandom_range(0, 1));
         bus.cpu_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         r = $urandom_range(0, 15);
         if (r <= 5)       bus.cpu_a = ($urandom_range(0, 1) != 0 ? 32'h0001_0000 : 32'h0) | 32'($urandom_range(0, 255));
         else if (r <= 9)  bus.cpu_a = RX;
         else if (r == 10) begin
            bus.cpu_a = CNT;
            if ($urandom_range(0, 15) != 0) bus.cpu_wr = 1'b0;
         end
         else if (r <= 13) bus.cpu_a = CNT + 32'($urandom_range(1, 3));
         else if (r == 14) bus.cpu_a = IDLE;
         else              bus.cpu_a = 32'h0013_0000;
         cycle();
      end

      rst_in = 1'b1; rdy_in = 1'b1;
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter TXQ_DEPTH, default 8, meaning UART transmit queue depth (power of two, 2..64).
REQ-002 SHALL have parameter RAM_ABITS, default 17, meaning the RAM address width.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rdy_in, input, 1 bit: global enable; all state freezes while it is low.
REQ-006 SHALL have ports cpu_a (input, 32), cpu_dout (input, 8) and cpu_wr (input, 1): the CPU address, write data and write strobe (1 = write).
REQ-007 SHALL have ports cpu_din (output, 8) and cpu_rdy (output, 1): the CPU read data and the CPU run enable.
REQ-008 SHALL have ports ram_a (output, RAM_ABITS), ram_dout (output, 8), ram_we (output, 1) and ram_din (input, 8): the RAM interface; RAM read latency is 1 cycle.
REQ-009 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_pop (output, 1): the UART receive byte, its availability, and its 1-cycle dequeue pulse.
REQ-010 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and io_buffer_full (input, 1): the UART transmit byte, its valid, and the UART backpressure.
REQ-011 SHALL have port halt (output, 1): program-stop indication, sticky.

Function
REQ-012 SHALL treat an access as IO when cpu_a[17:16]==2'b11; all other addresses are RAM.
REQ-013 SHALL define an access as valid only when cpu_rdy is 1; invalid accesses cause no state change.
REQ-014 SHALL drive ram_a = cpu_a[RAM_ABITS-1:0] and ram_dout = cpu_dout combinationally, with ram_we = cpu_wr & cpu_rdy & RAM region.
REQ-015 SHALL register the read source (RAM, RX, CNT byte n, or ZERO) for each valid read, and drive cpu_din from that source in the next cycle (1-cycle latency, matching RAM).
REQ-016 SHALL, on a valid read of 0x30000, return rx_data in the next cycle if rx_valid was 1 at the request, else 0x00, and pulse rx_pop in the request cycle only when rx_valid is 1.
REQ-017 SHALL keep a 32-bit free-running cycle counter that increments on every enabled cycle and wraps 0xFFFFFFFF->0.
REQ-018 SHALL, on a valid read of 0x30004, snapshot the counter.
REQ-019 SHALL serve reads of 0x30004/5/6/7 as snapshot bytes 0/1/2/3, so byte 0 returns the counter value at the 0x30004 request.
REQ-020 SHALL return 0x00 for reads of any other IO address.
REQ-021 SHALL, on a valid write of 0x30000 with nonzero data, enqueue the data byte; a zero byte SHALL be dropped.
REQ-022 SHALL, on a valid write of 0x30004, enqueue 0x00 as a terminator and enter state STOPPING.
REQ-023 SHALL, in STOPPING, ignore all further IO writes, and when the terminator is dequeued SHALL enter state HALTED and set halt=1.
REQ-024 SHALL implement a FIFO transmit queue with head, tail and a count of width clog2(TXQ_DEPTH)+1; pointers SHALL wrap modulo TXQ_DEPTH.
REQ-025 SHALL drive tx_valid = (count!=0) & ~io_buffer_full, with tx_data = the head entry, and dequeue one entry per cycle when tx_valid is 1.
REQ-026 SHALL drive cpu_rdy = rdy_in & (count!=TXQ_DEPTH) & (state!=HALTED); a full queue stalls the CPU (any access type) until one slot frees.
REQ-027 SHALL, on a same-cycle enqueue and dequeue, leave count unchanged; an enqueue into an empty queue SHALL become visible on tx_valid the following cycle.
REQ-028 SHALL, while rdy_in is 0, hold the counter, queue, state and snapshot, and force rx_pop=0, tx_valid=0 and ram_we=0.
REQ-029 SHALL have state machine states RUN -> STOPPING (on a 0x30004 write) -> HALTED (on terminator drain); HALTED is left only by reset.

Reset
REQ-030 SHALL, when rst_in=0 at a clock edge, set state=RUN, the counter to 0, the queue empty, the snapshot to 0 and the read source to ZERO.
REQ-031 SHALL hold the outputs at reset as cpu_din=0x00, halt=0, tx_valid=0, rx_pop=0, ram_we=0 and cpu_rdy=0.
REQ-032 SHALL let a reset mid-drain or in STOPPING discard queued bytes without emitting them.

Structure
REQ-033 SHALL place the IO address constants (0x30000, 0x30004), the region-decode constant 2'b11 and the state encoding in the shared const.v.
REQ-034 SHALL implement the transmit queue as one sub-module, mmio_txq (parameterised depth, push/pop/count).

Verification
REQ-035 SHALL verify RAM: write 0xA5 @0x00010, then read @0x00010 -> ram_we pulses 1 cycle, and cpu_din=0xA5 the cycle after the read.
REQ-036 SHALL verify TX filter: write 0x41, 0x00, 0x42 @0x30000 with io_buffer_full=0 -> tx_data emits 0x41, then 0x42, and nothing for the zero byte.
REQ-037 SHALL verify backpressure: io_buffer_full=1, then 9 writes @0x30000 with TXQ_DEPTH=8 -> cpu_rdy=0 after the 8th; release full -> cpu_rdy=1 the next cycle and all 9 bytes emitted in order.
REQ-038 SHALL verify the counter: read 0x30004..0x30007 at counter=0x000001F3 -> cpu_din returns 0xF3, 0x01, 0x00, 0x00 despite the counter advancing.
REQ-039 SHALL verify halt: write 0x30004 with 2 bytes queued -> 3 tx bytes with the last 0x00, halt=1 the cycle after the terminator, and cpu_rdy=0 thereafter.
REQ-040 SHALL verify reset: rst_in=0 for 1 cycle mid-drain (queue count 5) -> tx_valid=0, halt=0, and the counter restarts from 0.
